accum_n_bits_mode: RTL and testbench

- Parametrised N-bit accumulator with a registered operand stage and a result stage.
- Supports add, subtract, load and hold operations, with optional signed saturation, per-operation carry/borrow and overflow flags, and a sticky overflow flag.
- Successor to the board-level 8-bit add-only accumulator. Sits behind the switch/key front end; S feeds the hex display decoders.

---
 rtl/accum_n_bits_mode_if.sv | 25 ++
 rtl/accum_n_bits_mode.sv | 146 ++++++++++++++
 tb/tb_accum_n_bits_mode.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/accum_n_bits_mode_if.sv
// Operand/result bundle for the N-bit accumulator.
// The front end drives the master side and the accumulator is the slave.
interface accum_n_bits_mode_if #(
    parameter int unsigned N = 8
);
    logic         sclr;
    logic         en;
    logic [1:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] S;
    logic         carry;
    logic         overflow;
    logic         ovf_sticky;
    logic         valid;

    modport master (
        output sclr, en, op, A,
        input  S, carry, overflow, ovf_sticky, valid
    );

    modport slave (
        input  sclr, en, op, A,
        output S, carry, overflow, ovf_sticky, valid
    );
endinterface

// File: rtl/accum_n_bits_mode.sv
// N-bit accumulator: registered operand stage followed by a result stage.
// Supports hold/add/subtract/load, optional signed saturation, per-op
// carry/borrow and overflow flags, and a sticky overflow flag.
module accum_n_bits_mode #(
    parameter int unsigned N   = 8,
    parameter bit          SAT = 1'b0
) (
    input logic                 clk,
    input logic                 aclr,
    accum_n_bits_mode_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MIN = {1'b1, {(N-1){1'b0}}};

    // Stage 1 state
    logic [N-1:0] b_q, b_d;
    op_e          op_q, op_d;
    logic         v_q, v_d;

    // Stage 2 state
    logic [N-1:0] s_q, s_d;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         sticky_q, sticky_d;
    logic         valid_q, valid_d;

    // Arithmetic intermediates
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] res;
    logic         c_new;
    logic         o_new;

    // Stage 1 next state: capture operand on en, qualify with sclr
    always_comb begin
        b_d  = b_q;
        op_d = op_q;
        v_d  = bus.en & ~bus.sclr;
        if (bus.en) begin
            b_d  = bus.A;
            op_d = op_e'(bus.op);
        end
    end

    // Operation result and per-op flags from the registered operand
    always_comb begin
        sum   = {1'b0, s_q} + {1'b0, b_q};
        // Bit N of the zero-extended difference is the borrow (S < B unsigned)
        diff  = {1'b0, s_q} - {1'b0, b_q};
        res   = s_q;
        c_new = 1'b0;
        o_new = 1'b0;
        unique case (op_q)
            OP_HOLD: begin
                res = s_q;
            end
            OP_ADD: begin
                res   = sum[N-1:0];
                c_new = sum[N];
                o_new = (s_q[N-1] == b_q[N-1]) && (sum[N-1] != s_q[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                c_new = diff[N];
                o_new = (s_q[N-1] != b_q[N-1]) && (diff[N-1] != s_q[N-1]);
            end
            OP_LOAD: begin
                res = b_q;
            end
            default: begin
                res = s_q;
            end
        endcase
        // Clamp direction follows the sign of the pre-operation accumulator;
        // carry stays taken from the unsaturated result.
        if (SAT && o_new) begin
            res = s_q[N-1] ? NEG_MIN : POS_MAX;
        end
    end

    // Stage 2 next state: sclr, then idle hold, then apply the operation
    always_comb begin
        s_d      = s_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        valid_d  = 1'b0;
        if (bus.sclr) begin
            s_d      = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
        end else if (v_q) begin
            valid_d  = 1'b1;
            s_d      = res;
            carry_d  = c_new;
            ovf_d    = o_new;
            sticky_d = sticky_q | o_new;
        end
    end

    // Operand stage registers
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            b_q  <= '0;
            op_q <= OP_HOLD;
            v_q  <= 1'b0;
        end else begin
            b_q  <= b_d;
            op_q <= op_d;
            v_q  <= v_d;
        end
    end

    // Result stage registers
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            s_q      <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            s_q      <= s_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.S          = s_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = ovf_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.valid      = valid_q;

endmodule

// File: tb/tb_accum_n_bits_mode.sv
// Bench for accum_n_bits_mode: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share the same stimulus and are compared against an
// integer-arithmetic reference model of the accumulator.
module tb_accum_n_bits_mode;

    localparam int unsigned N = 8;

    logic clk;
    logic aclr;

    accum_n_bits_mode_if #(.N(N)) bus0 ();
    accum_n_bits_mode_if #(.N(N)) bus1 ();

    accum_n_bits_mode #(.N(N), .SAT(1'b0)) dut0 (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus0.slave)
    );

    accum_n_bits_mode #(.N(N), .SAT(1'b1)) dut1 (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = wrapping, 1 = saturating
    int m_s  [2];
    int m_c  [2];
    int m_o  [2];
    int m_st [2];
    int m_v  [2];
    int p_v;
    int p_op;
    int p_a;

    function automatic int to_signed(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s[k] = 0; m_c[k] = 0; m_o[k] = 0; m_st[k] = 0; m_v[k] = 0;
        end
        p_v = 0; p_op = 0; p_a = 0;
    endtask

    // One rising edge of the abstract machine: apply the pending operand,
    // then capture the new one.
    task automatic model_edge(input int sclr, input int en, input int op, input int a);
        int t;
        int res;
        int c;
        int o;
        for (int k = 0; k < 2; k++) begin
            if (sclr != 0) begin
                m_s[k] = 0; m_c[k] = 0; m_o[k] = 0; m_st[k] = 0; m_v[k] = 0;
            end else if (p_v == 0) begin
                m_v[k] = 0;
            end else begin
                t = 0; c = 0; o = 0; res = m_s[k];
                case (p_op)
                    1: begin
                        t   = to_signed(m_s[k]) + to_signed(p_a);
                        c   = (m_s[k] + p_a > 255) ? 1 : 0;
                        res = (m_s[k] + p_a) % 256;
                    end
                    2: begin
                        t   = to_signed(m_s[k]) - to_signed(p_a);
                        c   = (m_s[k] < p_a) ? 1 : 0;
                        res = (m_s[k] - p_a + 256) % 256;
                    end
                    3: res = p_a;
                    default: res = m_s[k];
                endcase
                if (p_op == 1 || p_op == 2)
                    o = (t > 127 || t < -128) ? 1 : 0;
                if (k == 1 && o != 0)
                    res = (t > 127) ? 127 : 128;
                m_s[k]  = res;
                m_c[k]  = c;
                m_o[k]  = o;
                m_st[k] = (m_st[k] != 0 || o != 0) ? 1 : 0;
                m_v[k]  = 1;
            end
        end
        p_v = (sclr == 0 && en != 0) ? 1 : 0;
        if (en != 0) begin
            p_op = op;
            p_a  = a;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/S0"},      {24'd0, bus0.S},          m_s[0]);
        check({tag, "/carry0"},  {31'd0, bus0.carry},      m_c[0]);
        check({tag, "/ovf0"},    {31'd0, bus0.overflow},   m_o[0]);
        check({tag, "/stick0"},  {31'd0, bus0.ovf_sticky}, m_st[0]);
        check({tag, "/valid0"},  {31'd0, bus0.valid},      m_v[0]);
        check({tag, "/S1"},      {24'd0, bus1.S},          m_s[1]);
        check({tag, "/carry1"},  {31'd0, bus1.carry},      m_c[1]);
        check({tag, "/ovf1"},    {31'd0, bus1.overflow},   m_o[1]);
        check({tag, "/stick1"},  {31'd0, bus1.ovf_sticky}, m_st[1]);
        check({tag, "/valid1"},  {31'd0, bus1.valid},      m_v[1]);
    endtask

    task automatic drive(input int sclr, input int en, input int op, input int a);
        bus0.sclr = sclr[0]; bus0.en = en[0]; bus0.op = op[1:0]; bus0.A = a[7:0];
        bus1.sclr = sclr[0]; bus1.en = en[0]; bus1.op = op[1:0]; bus1.A = a[7:0];
    endtask

    // Drive inputs, take one edge, update model, compare 1 time unit later
    task automatic step(input string tag, input int sclr, input int en, input int op, input int a);
        drive(sclr, en, op, a);
        @(posedge clk);
        model_edge(sclr, en, op, a);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        aclr = 1'b0;
        drive(0, 0, 0, 0);
        #3;
        check_all("reset");
        #5 aclr = 1'b1;

        // Basic add: load 0x10, add 0x05, add 0xF0
        step("b_ld",  0, 1, 3, 8'h10);
        step("b_a1",  0, 1, 1, 8'h05);
        check("b_S10", {24'd0, bus0.S}, 32'h10);
        step("b_a2",  0, 1, 1, 8'hF0);
        check("b_S15", {24'd0, bus0.S}, 32'h15);
        step("b_end", 0, 0, 0, 0);
        check("b_S05",  {24'd0, bus0.S}, 32'h05);
        check("b_c1",   {31'd0, bus0.carry}, 32'd1);
        check("b_o0",   {31'd0, bus0.overflow}, 32'd0);
        step("b_idle", 0, 0, 0, 0);
        check("b_novalid", {31'd0, bus0.valid}, 32'd0);

        // Signed overflow 0x7F + 1
        step("o_ld",  0, 1, 3, 8'h7F);
        step("o_add", 0, 1, 1, 8'h01);
        step("o_end", 0, 0, 0, 0);
        check("o_S0",  {24'd0, bus0.S}, 32'h80);
        check("o_S1",  {24'd0, bus1.S}, 32'h7F);
        check("o_ov1", {31'd0, bus1.overflow}, 32'd1);
        check("o_st0", {31'd0, bus0.ovf_sticky}, 32'd1);

        // Subtract with borrow from 0, then 0x80 - 1
        step("s_clr", 1, 0, 0, 0);
        step("s_sub", 0, 1, 2, 8'h01);
        step("s_r1",  0, 1, 3, 8'h80);
        check("s_FF", {24'd0, bus0.S}, 32'hFF);
        check("s_bw", {31'd0, bus0.carry}, 32'd1);
        step("s_sub2", 0, 1, 2, 8'h01);
        step("s_end",  0, 0, 0, 0);
        check("s_S0", {24'd0, bus0.S}, 32'h7F);
        check("s_S1", {24'd0, bus1.S}, 32'h80);

        // Back-to-back adds 1..4 from 0, then hold
        step("p_clr", 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step("p_add", 0, 1, 1, i);
        step("p_hold", 0, 1, 0, 8'hAA);
        check("p_S10", {24'd0, bus0.S}, 32'd10);
        step("p_end", 0, 0, 0, 0);
        check("p_hS",  {24'd0, bus0.S}, 32'd10);
        check("p_hv",  {31'd0, bus0.valid}, 32'd1);
        check("p_hc",  {31'd0, bus0.carry}, 32'd0);

        // sclr together with en: operand dropped
        step("c_ovf", 0, 1, 3, 8'h7F);
        step("c_sat", 0, 1, 1, 8'h7F);
        step("c_clr", 1, 1, 3, 8'h22);
        step("c_idle", 0, 0, 0, 0);
        check("c_S",  {24'd0, bus0.S}, 32'd0);
        check("c_v",  {31'd0, bus0.valid}, 32'd0);
        check("c_st", {31'd0, bus1.ovf_sticky}, 32'd0);

        // aclr between sampling a load and applying it
        step("r_ld", 0, 1, 3, 8'h55);
        drive(0, 0, 0, 0);
        #2 aclr = 1'b0;
        #1;
        model_reset();
        check_all("r_async");
        @(negedge clk);
        aclr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("r_post", 0, 0, 0, 0);
            check("r_no55", {31'd0, (bus0.S == 8'h55)}, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(15) == 0) ? 1 : 0,
                 ($urandom_range(3) != 0) ? 1 : 0,
                 int'($urandom_range(3)),
                 int'($urandom_range(255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
